// File: rtl/alu_seq_mdu.sv
// Sequential ALU with start/done handshake: single-cycle logic/arith ops plus
// iterative unsigned shift-add multiply and restoring divide.
module alu_seq_mdu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sig_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] OP_PASSB = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_NOTB  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Single-cycle ALU path, evaluated on the live operands at the accepting edge.
  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic             alu_ovf;

  assign add_res = A + B;
  assign sub_res = A - B;

  always_comb begin
    alu_res = B;
    alu_ovf = 1'b0;
    case (sig_op)
      OP_PASSB: alu_res = B;
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOTB: alu_res = ~B;
      default: alu_res = B;
    endcase
  end

  // Multiply: acc_hi holds the partial product, acc_lo the multiplier being
  // shifted out; the sum carry re-enters at the top on each right shift.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Divide: acc_hi is the remainder, acc_lo the dividend turning into quotient.
  // The shifted remainder is below 2*divisor, so a no-borrow trial fits WIDTH bits.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  assign div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, opnd_q};
  assign div_ge     = ~div_trial[WIDTH];
  assign div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nx = {acc_lo_q[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign iter_hi = is_div_q ? div_rem_nx : mul_hi_nx;
  assign iter_lo = is_div_q ? div_quo_nx : mul_lo_nx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sig_op == OP_MUL) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            is_div_d = 1'b0;
            opnd_d   = A;
            acc_hi_d = '0;
            acc_lo_d = B;
          end else if (sig_op == OP_DIVU && B != '0) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            is_div_d = 1'b1;
            opnd_d   = B;
            acc_hi_d = '0;
            acc_lo_d = A;
          end else if (sig_op == OP_DIVU) begin
            out_d    = '1;
            out_hi_d = A;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
          end else begin
            out_d    = alu_res;
            out_hi_d = '0;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          out_d    = iter_lo;
          out_hi_d = iter_hi;
          zero_d   = (iter_lo == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq_mdu.sv
// Randomised and directed checks of alu_seq_mdu (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_seq_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  sig_op;
  logic [15:0] A, B;
  logic        busy, done, zero, ovf;
  logic [15:0] out, out_hi;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq_mdu #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .sig_op(sig_op), .A(A), .B(B),
    .busy(busy), .done(done), .out(out), .out_hi(out_hi), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, b,
                                    output logic [15:0] lo, output logic [15:0] hi,
                                    output logic ov);
    int sa, sb, r;
    logic [63:0] p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    lo = 16'h0; hi = 16'h0; ov = 1'b0;
    case (op)
      3'd0: lo = b;
      3'd1: begin r = sa + sb; lo = r[15:0]; ov = (r > 32767) || (r < -32768); end
      3'd2: begin r = sa - sb; lo = r[15:0]; ov = (r > 32767) || (r < -32768); end
      3'd3: lo = a & b;
      3'd4: lo = a | b;
      3'd5: lo = ~b;
      3'd6: begin p = {48'd0, a} * {48'd0, b}; lo = p[15:0]; hi = p[31:16]; end
      default: begin
        if (b == 16'h0) begin lo = 16'hFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Issue one operation, then wait (bounded) for done while scrambling operands.
  // lat = edges after the accepting edge until done (-1 on timeout).
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, b,
                       output int lat, output int bc);
    start = 1'b1; sig_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bc = 0;
    while (!done && lat < 50) begin
      if (busy) bc++;
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sig_op = 3'd0; A = 16'h0; B = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out, out_hi, zero, ovf, done, busy} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset: out=%h hi=%h z=%b o=%b d=%b b=%b, required all 0",
               out, out_hi, zero, ovf, done, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    int lat, bc;
    do_op(3'd1, 16'h7FFF, 16'h0001, lat, bc);
    tests_run++;
    if (lat !== 0 || out !== 16'h8000 || ovf !== 1'b1 || zero !== 1'b0 || out_hi !== 16'h0) begin
      tests_failed++;
      $display("FAIL add_ovf: lat=%0d out=%h hi=%h ovf=%b zero=%b, required lat=0 out=8000 hi=0000 ovf=1 zero=0",
               lat, out, out_hi, ovf, zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || out !== 16'h8000) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b out=%h, required done=0 out=8000 (held)", done, out);
    end
    $display("[TB] ADD 7fff+0001 -> out=%h ovf=%b", out, ovf);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; sig_op = 3'd2; A = 16'h1234; B = 16'h1234;
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b1 || out !== 16'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_sub: done=%b out=%h zero=%b ovf=%b, required 1 0000 1 0", done, out, zero, ovf);
    end
    sig_op = 3'd3; A = 16'hF0F0; B = 16'h0FF0;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || out !== 16'h00F0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_and: done=%b out=%h zero=%b, required 1 00f0 0", done, out, zero);
    end
    $display("[TB] SUB then AND back-to-back -> out=%h", out);
  endtask

  task automatic test_mul();
    int lat, bc;
    do_op(3'd6, 16'hFFFF, 16'hFFFF, lat, bc);
    tests_run++;
    if (lat !== 16 || bc !== 16 || out_hi !== 16'hFFFE || out !== 16'h0001 || ovf !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_max: lat=%0d busy=%0d hi=%h out=%h ovf=%b zero=%b, required 16 16 fffe 0001 0 0",
               lat, bc, out_hi, out, ovf, zero);
    end
    $display("[TB] MUL ffff*ffff -> %h_%h lat=%0d", out_hi, out, lat);
  endtask

  task automatic test_divu();
    int lat;
    start = 1'b1; sig_op = 3'd7; A = 16'd1000; B = 16'd7;
    @(posedge clk); #1;
    lat = 0;
    // Random start pulses with garbage operations while busy must be ignored.
    while (!done && lat < 50) begin
      start = 1'($urandom); sig_op = 3'($urandom);
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    tests_run++;
    if (lat !== 16 || out !== 16'd142 || out_hi !== 16'd6 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_1000_7: lat=%0d out=%0d hi=%0d ovf=%b, required 16 142 6 0", lat, out, out_hi, ovf);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_no_queue: done=%b busy=%b, required 0 0", done, busy);
    end
    $display("[TB] DIVU 1000/7 -> q=%0d r=%0d", out, out_hi);
  endtask

  task automatic test_div_zero();
    int lat, bc;
    do_op(3'd7, 16'h00AB, 16'h0000, lat, bc);
    tests_run++;
    if (lat !== 0 || bc !== 0 || out !== 16'hFFFF || out_hi !== 16'h00AB || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero: lat=%0d busy=%0d out=%h hi=%h zero=%b, required 0 0 ffff 00ab 0",
               lat, bc, out, out_hi, zero);
    end
    $display("[TB] DIVU 00ab/0 -> out=%h hi=%h", out, out_hi);
  endtask

  task automatic test_reset_midrun();
    int lat, bc, dones;
    start = 1'b1; sig_op = 3'd6; A = 16'h1234; B = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({out, out_hi, zero, ovf, done, busy} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_midrun: out=%h hi=%h z=%b o=%b d=%b b=%b, required all 0",
               out, out_hi, zero, ovf, done, busy);
    end
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_discard: done/busy seen %0d cycles, required 0", dones);
    end
    do_op(3'd1, 16'd2, 16'd3, lat, bc);
    tests_run++;
    if (lat !== 0 || out !== 16'd5 || out_hi !== 16'd0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_after_reset: lat=%0d out=%0d hi=%0d ovf=%b, required 0 5 0 0", lat, out, out_hi, ovf);
    end
    $display("[TB] reset mid-MUL, then ADD 2+3 -> out=%0d", out);
  endtask

  task automatic test_random();
    int lat, bc, exp_lat;
    logic [2:0]  op;
    logic [15:0] a, b, e_lo, e_hi;
    logic        e_ov;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = (($urandom % 5) == 0) ? 16'h0 : 16'($urandom);
      if (($urandom % 6) == 0) a = 16'h0;
      ref_model(op, a, b, e_lo, e_hi, e_ov);
      exp_lat = (op == 3'd6 || (op == 3'd7 && b != 16'h0)) ? 16 : 0;
      do_op(op, a, b, lat, bc);
      tests_run++;
      if (lat !== exp_lat || bc !== exp_lat || out !== e_lo || out_hi !== e_hi ||
          ovf !== e_ov || zero !== (e_lo == 16'h0)) begin
        tests_failed++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: lat=%0d busy=%0d out=%h hi=%h ovf=%b zero=%b, required lat=%0d out=%h hi=%h ovf=%b zero=%b",
                 i, op, a, b, lat, bc, out, out_hi, ovf, zero, exp_lat, e_lo, e_hi, e_ov, (e_lo == 16'h0));
      end else begin
        $display("[TB] rand[%0d] op=%0d a=%h b=%h -> out=%h hi=%h ovf=%b zero=%b", i, op, a, b, out, out_hi, ovf, zero);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_mul();
    test_divu();
    test_div_zero();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
